vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-002 SHALL have parameters H_ACTIVE/H_FRONT/H_PULSE/H_BACK, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FRONT/V_PULSE/V_BACK, defaults 480/10/2/33, vertical timing in lines.
REQ-004 SHALL have parameters HS_POL, VS_POL, default 0/0, sync active level.
REQ-005 SHALL have parameter REQ_LEAD, default 2, range 0..8, cycles from data request to expected pixel data.
REQ-006 SHALL have ports iClk (in, 1, pixel clock) and iRst (in, 1, asynchronous active-high reset).
REQ-007 SHALL have ports iR/iG/iB (in, COLOR_W each, pixel data) and iValid (in, 1, pixel data valid).
REQ-008 SHALL have ports oR/oG/oB (out, COLOR_W each) and oHSync/oVSync/oDE (out, 1 each).
REQ-009 SHALL have ports oDataRequest (out, 1), oX (out, 12, requested column) and oY (out, 12, requested row).
REQ-010 SHALL have ports oFrameStart (out, 1, one-cycle pulse), oUnderflow (out, 1, sticky) and iClearErr (in, 1).

Function
REQ-011 SHALL run internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1); hc increments every cycle; vc increments when hc wraps; both wrap to 0 together at end of frame.
REQ-012 SHALL order each line/frame as active, front porch, pulse, back porch, with count 0 = first active pixel/line.
REQ-013 SHALL drive oDataRequest high, combinationally from counters, iff hc<H_ACTIVE and vc<V_ACTIVE; oX=hc, oY=vc when high, 0 otherwise.
REQ-014 SHALL sample iR/iG/iB/iValid exactly REQ_LEAD cycles after the corresponding request and present them on oR/oG/oB one cycle later (total REQ_LEAD+1).
REQ-015 SHALL register syncs and oDE and delay them by REQ_LEAD+1 so they align exactly with oR/oG/oB.
REQ-016 SHALL force oR/oG/oB to 0 whenever oDE is low.
REQ-017 SHALL assert oHSync at level HS_POL for H_PULSE cycles from hc=H_ACTIVE+H_FRONT, and oVSync at level VS_POL for V_PULSE whole lines from vc=V_ACTIVE+V_FRONT, both after the REQ-015 delay.
REQ-018 SHALL pulse oFrameStart for one cycle aligned with the first oDE of each frame (after the REQ-015 delay).
REQ-019 SHALL size counters with $clog2 of totals; oX/oY zero-extended to 12 bits.

Reset
REQ-020 SHALL on iRst clear hc, vc and all delay stages; outputs SHALL be oHSync=~HS_POL, oVSync=~VS_POL, oDE=0, RGB=0, oDataRequest=0 (driven 0 while iRst is high), oFrameStart=0, oUnderflow=0.
REQ-021 SHALL, on reset asserted mid-frame, restart at hc=vc=0 with oDataRequest high in the first cycle after deassertion.

Configuration
REQ-022 SHALL, with VGA_TIMING_GEN_UNDERFLOW_EN defined, set oUnderflow when a sampled pixel has iValid=0, output 0 on RGB for that pixel, and clear oUnderflow on iClearErr; set wins over simultaneous clear.
REQ-023 SHALL, without VGA_TIMING_GEN_UNDERFLOW_EN, ignore iValid and iClearErr and tie oUnderflow to 0.

Structure
REQ-024 SHALL take mode constants (640x480@60, 800x600@60 timing sets), the 12-bit coordinate width and the REQ_LEAD limit from shared package vga_pkg.
REQ-025 SHALL implement alignment delays in sub-module vga_delay_line (parametrised width and depth, depth 0 = wire, async active-high clear).

Verification
REQ-026 Defaults: measure oHSync -> period 800 cycles, low for 96 starting 656 cycles after first oDE of line; oVSync low for 2 lines, frame 525 lines.
REQ-027 REQ_LEAD=2, iR=oX[7:0] driven 2 cycles after request -> oR equals 0,1,2.. with oDE, first pixel appears 3 cycles after first oDataRequest.
REQ-028 HS_POL=VS_POL=1, 800x600 timing -> syncs active high, period 1056 cycles, oFrameStart once per 628 lines.
REQ-029 iRst pulsed at hc=300,vc=100 -> all outputs at reset values during reset; oX=0,oY=0 with oDataRequest first cycle after release.
REQ-030 UNDERFLOW_EN defined, iValid=0 for one active pixel -> that pixel RGB=0, oUnderflow=1 held until iClearErr; with macro undefined oUnderflow stays 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants: standard mode timings, coordinate width, request-lead limit
// and the flag bundle carried through the alignment pipeline.
package vga_pkg;

  localparam int COORD_W      = 12;
  localparam int REQ_LEAD_MAX = 8;

  typedef enum logic [0:0] {
    MODE_640X480_60 = 1'b0,
    MODE_800X600_60 = 1'b1
  } vgaMode_e;

  localparam int M640_H_ACTIVE = 640;
  localparam int M640_H_FRONT  = 16;
  localparam int M640_H_PULSE  = 96;
  localparam int M640_H_BACK   = 48;
  localparam int M640_V_ACTIVE = 480;
  localparam int M640_V_FRONT  = 10;
  localparam int M640_V_PULSE  = 2;
  localparam int M640_V_BACK   = 33;

  localparam int M800_H_ACTIVE = 800;
  localparam int M800_H_FRONT  = 40;
  localparam int M800_H_PULSE  = 128;
  localparam int M800_H_BACK   = 88;
  localparam int M800_V_ACTIVE = 600;
  localparam int M800_V_FRONT  = 1;
  localparam int M800_V_PULSE  = 4;
  localparam int M800_V_BACK   = 23;

  // Timing flags generated from the counters; sync fields mean "inside pulse", not a level.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } timingFlags_t;

  function automatic int spanTotal(input int active, input int front, input int pulse,
                                   input int back);
    return active + front + pulse + back;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline with asynchronous clear; depth 0 degenerates to a wire.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oD
);

  generate
    if (DEPTH == 0) begin : gWire
      logic unusedPins;
      assign unusedPins = iClk ^ iRst;
      assign oD = iD;
    end else begin : gPipe
      logic [WIDTH-1:0] stageR [DEPTH];

      // Shift register, stage 0 takes the input
      always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stageR[i] <= '0;
          end
        end else begin
          stageR[0] <= iD;
          for (int i = 1; i < DEPTH; i++) begin
            stageR[i] <= stageR[i-1];
          end
        end
      end

      assign oD = stageR[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with pixel-data request lead and aligned output registers.
// Optional underflow detection enabled by defining VGA_TIMING_GEN_UNDERFLOW_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W  = 8,
  parameter int H_ACTIVE = M640_H_ACTIVE,
  parameter int H_FRONT  = M640_H_FRONT,
  parameter int H_PULSE  = M640_H_PULSE,
  parameter int H_BACK   = M640_H_BACK,
  parameter int V_ACTIVE = M640_V_ACTIVE,
  parameter int V_FRONT  = M640_V_FRONT,
  parameter int V_PULSE  = M640_V_PULSE,
  parameter int V_BACK   = M640_V_BACK,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 2
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic [COLOR_W-1:0] iR,
  input  logic [COLOR_W-1:0] iG,
  input  logic [COLOR_W-1:0] iB,
  input  logic               iValid,
  output logic [COLOR_W-1:0] oR,
  output logic [COLOR_W-1:0] oG,
  output logic [COLOR_W-1:0] oB,
  output logic               oHSync,
  output logic               oVSync,
  output logic               oDE,
  output logic               oDataRequest,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic               oFrameStart,
  output logic               oUnderflow,
  input  logic               iClearErr
);

  localparam int H_TOTAL  = spanTotal(H_ACTIVE, H_FRONT, H_PULSE, H_BACK);
  localparam int V_TOTAL  = spanTotal(V_ACTIVE, V_FRONT, V_PULSE, V_BACK);
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int LEAD     = (REQ_LEAD > REQ_LEAD_MAX) ? REQ_LEAD_MAX : REQ_LEAD;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] hcR;
  logic [VW-1:0] vcR;
  timingFlags_t  flagsS;
  timingFlags_t  flagsD;
  logic          dataReqS;
  logic          validS;
  logic          pixelOkS;

  // Pixel and line counters; both wrap together at the end of the frame
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      hcR <= '0;
      vcR <= '0;
    end else if (hcR == H_LAST) begin
      hcR <= '0;
      if (vcR == V_LAST) begin
        vcR <= '0;
      end else begin
        vcR <= vcR + VW'(1);
      end
    end else begin
      hcR <= hcR + HW'(1);
    end
  end

  // Timing flags decoded straight from the counters (un-delayed request timebase)
  always_comb begin
    flagsS    = '0;
    flagsS.de = (int'(hcR) < H_ACTIVE) && (int'(vcR) < V_ACTIVE);
    flagsS.hs = (int'(hcR) >= HS_START) && (int'(hcR) < HS_START + H_PULSE);
    flagsS.vs = (int'(vcR) >= VS_START) && (int'(vcR) < VS_START + V_PULSE);
    flagsS.fs = (hcR == '0) && (vcR == '0);
    dataReqS  = flagsS.de && !iRst;
  end

  assign oDataRequest = dataReqS;
  assign oX           = dataReqS ? COORD_W'(hcR) : '0;
  assign oY           = dataReqS ? COORD_W'(vcR) : '0;

  // Flags wait LEAD cycles so they meet the pixel data sampled in the same cycle
  vga_delay_line #(
    .WIDTH ($bits(timingFlags_t)),
    .DEPTH (LEAD)
  ) uFlagDelay (
    .iClk (iClk),
    .iRst (iRst),
    .iD   (flagsS),
    .oD   (flagsD)
  );

`ifdef VGA_TIMING_GEN_UNDERFLOW_EN
  assign validS = iValid;

  // Sticky underflow: a missing pixel beats a simultaneous clear
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oUnderflow <= 1'b0;
    end else if (flagsD.de && !iValid) begin
      oUnderflow <= 1'b1;
    end else if (iClearErr) begin
      oUnderflow <= 1'b0;
    end else begin
      oUnderflow <= oUnderflow;
    end
  end
`else
  logic unusedInputs;
  assign unusedInputs = iValid ^ iClearErr;
  assign validS       = 1'b1;
  assign oUnderflow   = 1'b0;
`endif

  assign pixelOkS = flagsD.de && validS;

  // Output register stage: sample pixel data and apply sync polarity
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
      oDE         <= 1'b0;
      oHSync      <= ~HS_POL;
      oVSync      <= ~VS_POL;
      oFrameStart <= 1'b0;
    end else begin
      oDE         <= flagsD.de;
      oHSync      <= flagsD.hs ? HS_POL : ~HS_POL;
      oVSync      <= flagsD.vs ? VS_POL : ~VS_POL;
      oFrameStart <= flagsD.fs;
      if (pixelOkS) begin
        oR <= iR;
        oG <= iG;
        oB <= iB;
      end else begin
        oR <= '0;
        oG <= '0;
        oB <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small timing set with randomized pixel data.
module tb_vga_timing_gen;

  localparam int CW   = 8;
  localparam int HA   = 16;
  localparam int HF   = 2;
  localparam int HP   = 3;
  localparam int HB   = 2;
  localparam int VA   = 6;
  localparam int VF   = 1;
  localparam int VP   = 2;
  localparam int VB   = 1;
  localparam int LEAD = 2;
  localparam bit HSP  = 1'b1;
  localparam bit VSP  = 1'b0;
  localparam int HT   = HA + HF + HP + HB;
  localparam int VT   = VA + VF + VP + VB;
`ifdef VGA_TIMING_GEN_UNDERFLOW_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          iRst;
  logic [CW-1:0] iR, iG, iB;
  logic          iValid, iClearErr;
  logic [CW-1:0] oR, oG, oB;
  logic          oHSync, oVSync, oDE, oDataRequest, oFrameStart, oUnderflow;
  logic [11:0]   oX, oY;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .COLOR_W (CW),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
    .HS_POL  (HSP), .VS_POL(VSP),
    .REQ_LEAD(LEAD)
  ) dut (
    .iClk(clk), .iRst(iRst),
    .iR(iR), .iG(iG), .iB(iB), .iValid(iValid),
    .oR(oR), .oG(oG), .oB(oB),
    .oHSync(oHSync), .oVSync(oVSync), .oDE(oDE),
    .oDataRequest(oDataRequest), .oX(oX), .oY(oY),
    .oFrameStart(oFrameStart), .oUnderflow(oUnderflow), .iClearErr(iClearErr)
  );

  typedef struct {
    logic          req;
    logic [11:0]   x, y;
    logic          de, hs, vs, fs, uf;
    logic [CW-1:0] r, g, b;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  // model state: cycle index since reset release and previous-cycle inputs
  int            n = -1;
  logic [CW-1:0] prevR, prevG, prevB;
  bit            prevValid, prevClear;
  bit            modelUf;

  function automatic exp_t idleExp();
    exp_t e;
    e.req = 1'b0; e.x = 12'd0; e.y = 12'd0;
    e.de = 1'b0; e.hs = ~HSP; e.vs = ~VSP; e.fs = 1'b0; e.uf = 1'b0;
    e.r = '0; e.g = '0; e.b = '0;
    return e;
  endfunction

  function automatic int colOf(input int p);
    return p % HT;
  endfunction

  function automatic int rowOf(input int p);
    return (p / HT) % VT;
  endfunction

  task automatic step(input bit rst);
    exp_t e;
    int   p;
    bit   pixOk;
    @(posedge clk);
    #1;
    iRst      = rst;
    iR        = CW'($urandom);
    iG        = CW'($urandom);
    iB        = CW'($urandom);
    iValid    = ($urandom_range(15) != 0);
    iClearErr = ($urandom_range(31) == 0);
    e = idleExp();
    if (rst) begin
      n       = -1;
      modelUf = 1'b0;
    end else begin
      n++;
      e.req = (colOf(n) < HA) && (rowOf(n) < VA);
      e.x   = e.req ? 12'(colOf(n)) : 12'd0;
      e.y   = e.req ? 12'(rowOf(n)) : 12'd0;
      if (n > 0) begin
        p = n - 1 - LEAD;
        if (p >= 0) begin
          e.de = (colOf(p) < HA) && (rowOf(p) < VA);
          e.hs = ((colOf(p) >= HA + HF) && (colOf(p) < HA + HF + HP)) ? HSP : ~HSP;
          e.vs = ((rowOf(p) >= VA + VF) && (rowOf(p) < VA + VF + VP)) ? VSP : ~VSP;
          e.fs = (colOf(p) == 0) && (rowOf(p) == 0);
        end
        pixOk = e.de && (prevValid || !UF_EN);
        e.r = pixOk ? prevR : '0;
        e.g = pixOk ? prevG : '0;
        e.b = pixOk ? prevB : '0;
        if (UF_EN) begin
          if (e.de && !prevValid) modelUf = 1'b1;
          else if (prevClear) modelUf = 1'b0;
        end
      end
      e.uf = modelUf;
    end
    expQ.push_back(e);
    prevR = iR; prevG = iG; prevB = iB;
    prevValid = iValid; prevClear = iClearErr;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one output per clock, compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("dataRequest", 32'(oDataRequest), 32'(e.req));
        chk("oX", 32'(oX), 32'(e.x));
        chk("oY", 32'(oY), 32'(e.y));
        chk("oDE", 32'(oDE), 32'(e.de));
        chk("oHSync", 32'(oHSync), 32'(e.hs));
        chk("oVSync", 32'(oVSync), 32'(e.vs));
        chk("oFrameStart", 32'(oFrameStart), 32'(e.fs));
        chk("oR", 32'(oR), 32'(e.r));
        chk("oG", 32'(oG), 32'(e.g));
        chk("oB", 32'(oB), 32'(e.b));
        chk("oUnderflow", 32'(oUnderflow), 32'(e.uf));
      end
    end
  end

  initial begin
    iRst = 1'b1; iR = '0; iG = '0; iB = '0; iValid = 1'b0; iClearErr = 1'b0;
    prevR = '0; prevG = '0; prevB = '0; prevValid = 1'b0; prevClear = 1'b0; modelUf = 1'b0;
    repeat (3) step(1'b1);
    repeat (2 * HT * VT + 57) step(1'b0);
    repeat (2) step(1'b1);
    repeat (3 * HT * VT + 10) step(1'b0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
